// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the immediate generator buffer.
// Holds the immediate type encoding, the occupancy states of the
// two-entry output queue, the RISC-V opcodes used by the optional
// opcode-driven type decode, and a sign-extension helper.
package imm_gen_pkg;

   typedef enum logic [2:0] {
      IMM_I   = 3'd0,
      IMM_S   = 3'd1,
      IMM_B   = 3'd2,
      IMM_U   = 3'd3,
      IMM_J   = 3'd4,
      IMM_Z   = 3'd5,
      IMM_ILL = 3'd6
   } imm_type_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } fifo_state_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // Widen a 32-bit value to 64 bits by replicating its top bit.
   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/imm_gen_buf_if.sv
// Handshake bundle for the immediate generator buffer: an instruction
// input side and a formatted-immediate output side, each valid/ready.
interface imm_gen_buf_if #(parameter int XLEN = 32);

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [2:0]      in_sel;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_type;
   logic            out_err;

   modport master (
      output in_valid, in_instr, in_sel, out_ready,
      input  in_ready, out_valid, out_imm, out_type, out_err
   );

   modport slave (
      input  in_valid, in_instr, in_sel, out_ready,
      output in_ready, out_valid, out_imm, out_type, out_err
   );

endinterface

// File: rtl/imm_gen_buf_format.sv
// imm_format: purely combinational immediate formatter. Builds the
// 32-bit immediate for the given type, then widens it to XLEN with
// sign replication (or zero fill for the CSR zimm type). Unknown
// types produce zero and raise o_err.
module imm_format
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     i_instr,
   input  logic [2:0]      i_type,
   output logic [XLEN-1:0] o_imm,
   output logic            o_err
);

   logic [31:0] w_raw;
   logic        w_signed;
   logic [63:0] w_ext;
   logic        w_unusedBits;

   // Select the bit scatter for the requested immediate type.
   always_comb begin
      w_raw    = '0;
      w_signed = 1'b1;
      o_err    = 1'b0;
      case (i_type)
         IMM_I: w_raw = {{20{i_instr[31]}}, i_instr[31:20]};
         IMM_S: w_raw = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         IMM_B: w_raw = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
         IMM_U: w_raw = {i_instr[31:12], 12'b0};
         IMM_J: w_raw = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
         IMM_Z: begin
            w_raw    = {27'b0, i_instr[19:15]};
            w_signed = 1'b0;
         end
         default: begin
            w_raw    = '0;
            w_signed = 1'b0;
            o_err    = 1'b1;
         end
      endcase
   end

   assign w_ext = w_signed ? sext32(w_raw) : {32'b0, w_raw};
   assign o_imm = w_ext[XLEN-1:0];

   // Opcode bits never feed the formatter and the upper half is only
   // needed for 64-bit builds.
   assign w_unusedBits = ^{i_instr[6:0], w_ext[63:32]};

endmodule

// File: rtl/imm_gen_buf.sv
// imm_gen_buf: formats RISC-V immediates on accept and queues the
// result, its type and an illegal-type flag in a two-entry FIFO.
// Optional build macro IMM_GEN_AUTODECODE_EN: when defined, the type is
// derived from the instruction opcode and in_sel is ignored; otherwise
// the type comes straight from in_sel.
module imm_gen_buf
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic         clk,
   input  logic         rst,
   imm_gen_buf_if.slave bus
);

   fifo_state_t     r_state;
   logic            r_outValid;
   logic            r_notFull;
   logic            r_wrPtr;
   logic            r_rdPtr;
   logic [XLEN-1:0] r_immMem  [2];
   logic [2:0]      r_typeMem [2];
   logic            r_errMem  [2];

   logic [2:0]      w_type;
   logic [XLEN-1:0] w_imm;
   logic            w_err;
   logic            w_inReady;
   logic            w_push;
   logic            w_pop;

`ifdef IMM_GEN_AUTODECODE_EN
   logic            w_unusedSel;

   // Map the major opcode onto an immediate type; SYSTEM splits on
   // funct3[2] between CSR-immediate and register forms.
   always_comb begin
      w_type = IMM_ILL;
      case (bus.in_instr[6:0])
         OPC_OP_IMM, OPC_LOAD, OPC_JALR: w_type = IMM_I;
         OPC_STORE:                      w_type = IMM_S;
         OPC_BRANCH:                     w_type = IMM_B;
         OPC_LUI, OPC_AUIPC:             w_type = IMM_U;
         OPC_JAL:                        w_type = IMM_J;
         OPC_SYSTEM:                     w_type = bus.in_instr[14] ? IMM_Z : IMM_I;
         default:                        w_type = IMM_ILL;
      endcase
   end

   assign w_unusedSel = ^bus.in_sel;
`else
   assign w_type = bus.in_sel;
`endif

   imm_format #(.XLEN(XLEN)) u_format (
      .i_instr (bus.in_instr),
      .i_type  (w_type),
      .o_imm   (w_imm),
      .o_err   (w_err)
   );

   // Ready is forced low while reset is held, so nothing is accepted
   // until the first rising edge after release.
   assign w_inReady = rst & r_notFull;
   assign w_push    = bus.in_valid & w_inReady;
   assign w_pop     = r_outValid & bus.out_ready;

   // Occupancy FSM with registered valid/not-full flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_EMPTY;
         r_outValid <= 1'b0;
         r_notFull  <= 1'b1;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_push) begin
                  r_state    <= ST_ONE;
                  r_outValid <= 1'b1;
               end
            end
            ST_ONE: begin
               if (w_push && !w_pop) begin
                  r_state   <= ST_FULL;
                  r_notFull <= 1'b0;
               end else if (w_pop && !w_push) begin
                  r_state    <= ST_EMPTY;
                  r_outValid <= 1'b0;
               end
            end
            ST_FULL: begin
               if (w_pop) begin
                  r_state   <= ST_ONE;
                  r_notFull <= 1'b1;
               end
            end
            default: begin
               r_state    <= ST_EMPTY;
               r_outValid <= 1'b0;
               r_notFull  <= 1'b1;
            end
         endcase
      end
   end

   // Storage and 1-bit wrapping pointers; reset clears entries so the
   // head outputs read zero while empty after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wrPtr <= 1'b0;
         r_rdPtr <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            r_immMem[i]  <= '0;
            r_typeMem[i] <= '0;
            r_errMem[i]  <= 1'b0;
         end
      end else begin
         if (w_push) begin
            r_immMem[r_wrPtr]  <= w_imm;
            r_typeMem[r_wrPtr] <= w_type;
            r_errMem[r_wrPtr]  <= w_err;
            r_wrPtr            <= ~r_wrPtr;
         end
         if (w_pop) begin
            r_rdPtr <= ~r_rdPtr;
         end
      end
   end

   assign bus.in_ready  = w_inReady;
   assign bus.out_valid = r_outValid;
   assign bus.out_imm   = r_immMem[r_rdPtr];
   assign bus.out_type  = r_typeMem[r_rdPtr];
   assign bus.out_err   = r_errMem[r_rdPtr];

endmodule
